ram_arbiter: RTL and testbench

Shares the single-port 32K×8 work RAM between the 65C02 bus and a secondary bus master (DMA/blitter), all clocked by the 63 MHz system clock. The CPU owns the RAM whenever its clock phase is low and it decodes a RAM address. The DMA port is served in all remaining cycles through a req/ack handshake. The block also records the worst-case DMA stall for bring-up.

---
 rtl/ram_arbiter.sv | 100 ++++++++++
 tb/tb_ram_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - work RAM arbiter between the 65C02 bus and a DMA master
// The CPU always wins in its low phase. DMA runs a req/ack handshake in the remaining cycles.
module ram_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_phase,
  input  logic              cpu_sel,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [7:0]        dma_wait_max,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic {D_IDLE, D_ACK} dma_state_t;

  dma_state_t state, state_next;
  logic       cpu_grant;
  logic       dma_issue;
  logic       cpu_rd_pend;
  logic [7:0] cur_wait;

  assign cpu_grant = ~cpu_phase & cpu_sel;

  always_ff @(posedge clk) begin
    if (reset) state <= D_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    dma_issue  = 1'b0;
    case (state)
      D_IDLE: begin
        if (dma_req && !cpu_grant) begin
          dma_issue  = 1'b1;
          state_next = D_ACK;
        end
      end
      D_ACK:   state_next = D_IDLE;
      default: state_next = D_IDLE;
    endcase
  end

  // Idle cycles still present the DMA address; only the write enable is withheld.
  always_comb begin
    ram_addr  = dma_addr;
    ram_wdata = dma_wdata;
    ram_we    = 1'b0;
    if (cpu_grant) begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_we    = cpu_we;
    end else if (dma_issue) begin
      ram_we = dma_we;
    end
    if (reset) ram_we = 1'b0;
  end

  assign dma_ack   = (state == D_ACK);
  assign dma_rdata = dma_ack ? ram_rdata : '0;

  // RAM data lags its address by one cycle, so a CPU read lands one cycle after its grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_rd_pend <= 1'b0;
      cpu_rdata   <= '0;
    end else begin
      cpu_rd_pend <= cpu_grant & ~cpu_we;
      if (cpu_rd_pend && !cpu_phase) cpu_rdata <= ram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_wait     <= 8'd0;
      dma_wait_max <= 8'd0;
    end else begin
      if (dma_issue || !dma_req)
        cur_wait <= 8'd0;
      else if (state == D_IDLE && cpu_grant && cur_wait != 8'hff)
        cur_wait <= cur_wait + 8'd1;
      if (cur_wait > dma_wait_max) dma_wait_max <= cur_wait;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter with RAM and scoreboard models
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_phase, cpu_sel, cpu_we;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_ack;
  logic [14:0] dma_addr;
  logic [7:0]  dma_wdata, dma_rdata, dma_wait_max;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata, ram_rdata;

  logic        mem_clr;
  logic [7:0]  tb_mem [0:32767];
  logic [7:0]  ref_mem [0:31];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(15), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_phase(cpu_phase), .cpu_sel(cpu_sel), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .dma_wait_max(dma_wait_max),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Single-port synchronous RAM: read-before-write, data one cycle after address.
  always @(posedge clk) begin
    if (mem_clr) begin
      foreach (tb_mem[i]) tb_mem[i] <= 8'h00;
    end else begin
      if (ram_we) tb_mem[ram_addr] <= ram_wdata;
      ram_rdata <= tb_mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic dma_xfer(input logic we, input logic [14:0] addr, input logic [7:0] data,
                          input logic [7:0] exp_rd);
    dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = data;
    @(negedge clk);
    check("xfer_issue_we", ram_we, we);
    check("xfer_issue_addr", ram_addr, addr);
    check("xfer_issue_noack", dma_ack, 1'b0);
    cyc();
    @(negedge clk);
    check("xfer_ack", dma_ack, 1'b1);
    check("xfer_ack_we", ram_we, 1'b0);
    if (!we) check("xfer_rdata", dma_rdata, exp_rd);
    cyc();
    dma_req = 1'b0;
    @(negedge clk);
    check("xfer_after_ack", dma_ack, 1'b0);
    cyc();
  endtask

  logic       grant, issue, saw_ack;
  logic       m_ack, m_wr, m_pend;
  logic [7:0] m_dexp, m_cpu, m_pval;
  int         phase_left;

  initial begin
    reset = 1'b1; mem_clr = 1'b1;
    cpu_phase = 1'b1; cpu_sel = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    foreach (ref_mem[i]) ref_mem[i] = 8'h00;
    cyc(); cyc();
    mem_clr = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("rst_ack", dma_ack, 1'b0);
    check("rst_rdata", dma_rdata, 8'h00);
    check("rst_cpu_rdata", cpu_rdata, 8'h00);
    check("rst_wait_max", dma_wait_max, 8'h00);
    check("rst_ram_we", ram_we, 1'b0);
    cyc();

    // DMA write then read-back with the CPU deselected
    dma_xfer(1'b1, 15'h1234, 8'hA5, 8'h00);
    dma_xfer(1'b0, 15'h1234, 8'h00, 8'hA5);
    dma_xfer(1'b1, 15'h0010, 8'h3C, 8'h00);
    dma_xfer(1'b1, 15'h0200, 8'h5A, 8'h00);

    // CPU read during a 4-clk low phase with DMA pending
    cpu_phase = 1'b0; cpu_sel = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0010;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 15'h0200;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("cont_ram_we", ram_we, 1'b0);
      check("cont_ram_addr", ram_addr, 15'h0010);
      check("cont_noack", dma_ack, 1'b0);
      if (i == 3) check("cont_cpu_rdata", cpu_rdata, 8'h3C);
      cyc();
    end
    cpu_phase = 1'b1; cpu_sel = 1'b0;
    @(negedge clk);
    check("cont_issue_addr", ram_addr, 15'h0200);
    check("cont_issue_noack", dma_ack, 1'b0);
    cyc();
    @(negedge clk);
    check("cont_ack", dma_ack, 1'b1);
    check("cont_dma_rdata", dma_rdata, 8'h5A);
    check("stall_max4", dma_wait_max, 8'd4);
    check("cont_cpu_hold", cpu_rdata, 8'h3C);
    cyc();
    dma_req = 1'b0;
    cyc();

    // Back-to-back DMA writes with req held high
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 15'h0300; dma_wdata = 8'h11;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check("b2b_ack", dma_ack, (i % 2 == 0));
      check("b2b_ram_we", ram_we, (i % 2 != 0));
      cyc();
      if (i % 2 == 0) begin
        dma_addr = 15'h0300 + 15'(i / 2);
        dma_wdata = 8'h11 + 8'(i);
      end
    end
    dma_req = 1'b0;
    @(negedge clk);
    check("b2b_done", dma_ack, 1'b0);
    check("b2b_mem", tb_mem[15'h0302], 8'h15);
    cyc();

    // Stall saturation over a 300-cycle CPU low phase
    cpu_phase = 1'b0; cpu_sel = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0010;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 15'h0200;
    repeat (300) cyc();
    cpu_phase = 1'b1; cpu_sel = 1'b0;
    cyc();
    @(negedge clk);
    check("sat_ack", dma_ack, 1'b1);
    check("sat_max255", dma_wait_max, 8'd255);
    cyc();
    dma_req = 1'b0;
    cyc();

    // Reset arriving in a DMA issue cycle
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 15'h0400; dma_wdata = 8'h77; reset = 1'b1;
    @(negedge clk);
    check("rst_issue_we", ram_we, 1'b0);
    cyc();
    reset = 1'b0; dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    @(negedge clk);
    check("rst2_ack", dma_ack, 1'b0);
    check("rst2_rdata", dma_rdata, 8'h00);
    check("rst2_cpu_rdata", cpu_rdata, 8'h00);
    check("rst2_wait_max", dma_wait_max, 8'h00);
    check("rst2_ram_we", ram_we, 1'b0);
    check("rst2_ram_addr", ram_addr, 15'h0000);
    check("rst2_ram_wdata", ram_wdata, 8'h00);
    check("rst2_nowrite", tb_mem[15'h0400], 8'h00);
    cyc();

    // Randomised traffic against a scoreboard of the last value written per address
    m_ack = 1'b0; m_wr = 1'b0; m_pend = 1'b0; m_dexp = 8'h00; m_cpu = 8'h00; m_pval = 8'h00;
    phase_left = 1;
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      grant = !cpu_phase && cpu_sel;
      check("rnd_ack", dma_ack, m_ack);
      if (m_ack && !m_wr) check("rnd_dma_rdata", dma_rdata, m_dexp);
      if (m_ack && !grant) check("rnd_ack_we", ram_we, 1'b0);
      check("rnd_cpu_rdata", cpu_rdata, m_cpu);
      issue = !m_ack && dma_req && !grant;
      if (m_pend && !cpu_phase) m_cpu = m_pval;
      m_pend = grant && !cpu_we;
      if (grant) m_pval = ref_mem[cpu_addr[4:0]];
      if (issue) begin
        m_dexp = ref_mem[dma_addr[4:0]];
        m_wr = dma_we;
      end
      if (grant && cpu_we) ref_mem[cpu_addr[4:0]] = cpu_wdata;
      else if (issue && dma_we) ref_mem[dma_addr[4:0]] = dma_wdata;
      saw_ack = m_ack;
      m_ack = issue;
      cyc();
      if (!dma_req || saw_ack) begin
        dma_req = ($urandom_range(0, 3) != 0);
        dma_we = 1'($urandom);
        dma_addr = 15'h2000 + 15'($urandom_range(0, 31));
        dma_wdata = 8'($urandom);
      end
      phase_left--;
      if (phase_left == 0) begin
        cpu_phase = ~cpu_phase;
        if (!cpu_phase) begin
          phase_left = $urandom_range(2, 5);
          cpu_sel = ($urandom_range(0, 3) != 0);
          cpu_we = 1'($urandom);
          cpu_addr = 15'h2000 + 15'($urandom_range(0, 31));
          cpu_wdata = 8'($urandom);
        end else begin
          phase_left = $urandom_range(1, 4);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
